// File: rtl/stall_pkg.sv
// stall_pkg
// Shared definitions for the pipeline stall/flush controller:
//   - stage indices into the stall vector (PC .. WB) and the stage count
//   - the multi-cycle FSM state encoding
//   - the stall vector produced for each stall level
// Ports: none (package).
package stall_pkg;

  localparam int STG_PC     = 0;
  localparam int STG_IF     = 1;
  localparam int STG_ID     = 2;
  localparam int STG_EX     = 3;
  localparam int STG_MEM    = 4;
  localparam int STG_WB     = 5;
  localparam int NUM_STAGES = 6;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MC_BUSY = 1'b1
  } mc_state_e;

  // Each level freezes every stage up to and including the one that cannot
  // advance, so the vectors are monotone and WB is never held.
  localparam logic [NUM_STAGES-1:0] STALL_NONE = 6'b000000;
  localparam logic [NUM_STAGES-1:0] STALL_LU   = 6'b000111;
  localparam logic [NUM_STAGES-1:0] STALL_MC   = 6'b001111;
  localparam logic [NUM_STAGES-1:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/stall_ctrl_hazard_detect.sv
// hazard_detect
// Combinational load-use comparator. Flags when the load currently in EX
// writes a register that the instruction in ID actually reads. x0 is never
// a hazard because it is hard-wired to zero. Flush gating is applied by the
// caller.
// Ports:
//   id_rs1_i, id_rs2_i           : source registers of the ID instruction
//   id_rs1_used_i, id_rs2_used_i : the corresponding source is really read
//   ex_rd_i                      : destination register of the EX instruction
//   ex_mem_read_i                : EX instruction is a load
//   lu_raw_o                     : raw load-use hazard condition
module hazard_detect (
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  output logic       lu_raw_o
);

  logic rs1_hit;
  logic rs2_hit;

  // A source only matters when it is both read and equal to the load target.
  assign rs1_hit  = id_rs1_used_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit  = id_rs2_used_i && (id_rs2_i == ex_rd_i);
  assign lu_raw_o = ex_mem_read_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl
// Pipeline stall/flush controller for the 5-stage core. Arbitrates memory
// wait states, multi-cycle EX ops and load-use hazards into one monotone
// stall vector (highest level wins) and generates the taken-branch flushes.
// All stall/flush outputs are combinational from inputs and state.
// Optional feature: define STALL_CTRL_PERF_EN to add saturating 32-bit
// cycle counters perf_lu / perf_mc / perf_mem of the winning stall level.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   id_rs1/id_rs2, *_used      : ID source registers and their use flags
//   ex_rd, ex_mem_read         : EX destination and load flag
//   ex_mc_start                : EX holds a multi-cycle op
//   ex_branch_taken            : branch in EX resolved taken
//   mem_req, mem_ready         : data-memory request / completion
//   stall[5:0]                 : PC, IF, ID, EX, MEM, WB hold bits
//   flush_if_id, flush_id_ex   : zero the register at the next edge
//   mc_busy, mc_done           : multi-cycle FSM busy / last EX cycle
//   mem_timeout                : one-cycle pulse after too many wait cycles
module stall_ctrl
  import stall_pkg::*;
#(
  parameter int MC_LAT      = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_mc_start,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  mc_busy,
  output logic                  mc_done,
  output logic                  mem_timeout
`ifdef STALL_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_lu,
  output logic [31:0]           perf_mc,
  output logic [31:0]           perf_mem
`endif
);

  localparam int CW = $clog2(MC_LAT);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  mc_state_e       state_q, state_d;
  logic [CW-1:0]   mc_cnt_q, mc_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;

  logic            mem_wait;
  logic            mc_stall;
  logic            mc_last;
  logic            to_hit;
  logic            lu_raw;
  logic            lu_stall;
  logic            ex_held;
  logic            flush;

  hazard_detect u_hazard_detect (
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_rs1_used_i (id_rs1_used),
    .id_rs2_used_i (id_rs2_used),
    .ex_rd_i       (ex_rd),
    .ex_mem_read_i (ex_mem_read),
    .lu_raw_o      (lu_raw)
  );

  assign mem_wait = mem_req && !mem_ready;

  // State registers. Reset drops any op in flight straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mc_cnt_q <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Multi-cycle FSM. The accepting cycle is EX cycle 1 and already stalls;
  // mc_cnt then counts the remaining EX cycles and freezes during memory
  // waits because the whole pipe (EX included) is held then. Starts are
  // ignored while busy since the same op is simply being held in EX.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    mc_stall = 1'b0;
    mc_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_mc_start && !mem_wait) begin
          state_d  = ST_MC_BUSY;
          mc_cnt_d = CW'(MC_LAT - 1);
          mc_stall = 1'b1;
        end
      end
      ST_MC_BUSY: begin
        mc_stall = (mc_cnt_q > CW'(1));
        if (!mem_wait) begin
          if (mc_cnt_q == CW'(1)) begin
            mc_last  = 1'b1;
            state_d  = ST_IDLE;
            mc_cnt_d = '0;
          end else begin
            mc_cnt_d = mc_cnt_q - CW'(1);
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        mc_cnt_d = '0;
      end
    endcase
  end

  // Wait-state watchdog: counts consecutive wait cycles and restarts after
  // each pulse, so a long wait produces a pulse every MEM_TIMEOUT cycles.
  always_comb begin
    to_cnt_d = '0;
    to_hit   = 1'b0;
    if (mem_wait) begin
      if (to_cnt_q == TW'(MEM_TIMEOUT - 1)) begin
        to_hit = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  // Stall arbitration and flush. ex_held is the EX hold bit computed without
  // the load-use term (which never reaches EX), breaking the loop between
  // flush, lu_stall and the stall vector. A flush kills the wrong-path ID
  // instruction, so it cannot cause a load-use stall.
  always_comb begin
    ex_held  = mem_wait || mc_stall;
    flush    = rst_n && ex_branch_taken && !ex_held;
    lu_stall = lu_raw && !flush;
    stall    = STALL_NONE;
    if (rst_n) begin
      if (mem_wait) begin
        stall = STALL_MEM;
      end else if (mc_stall) begin
        stall = STALL_MC;
      end else if (lu_stall) begin
        stall = STALL_LU;
      end
    end
  end

  assign flush_if_id = flush;
  assign flush_id_ex = flush;
  assign mc_busy     = (state_q == ST_MC_BUSY);
  assign mc_done     = rst_n && mc_last;
  assign mem_timeout = rst_n && to_hit;

`ifdef STALL_CTRL_PERF_EN
  logic [31:0] perf_lu_q, perf_mc_q, perf_mem_q;

  // Cycle counters of the winning stall level; they stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_q  <= '0;
      perf_mc_q  <= '0;
      perf_mem_q <= '0;
    end else begin
      if (stall == STALL_LU && perf_lu_q != '1) begin
        perf_lu_q <= perf_lu_q + 32'd1;
      end
      if (stall == STALL_MC && perf_mc_q != '1) begin
        perf_mc_q <= perf_mc_q + 32'd1;
      end
      if (stall == STALL_MEM && perf_mem_q != '1) begin
        perf_mem_q <= perf_mem_q + 32'd1;
      end
    end
  end

  assign perf_lu  = perf_lu_q;
  assign perf_mc  = perf_mc_q;
  assign perf_mem = perf_mem_q;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl
// Self-checking bench for stall_ctrl (MC_LAT=4, MEM_TIMEOUT=3). Directed
// sequences with literal expectations, then randomized traffic checked every
// cycle against a behavioural model of the stall rules.
module tb_stall_ctrl;

  localparam int MC_LAT      = 4;
  localparam int MEM_TIMEOUT = 3;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used;
  logic       ex_mem_read, ex_mc_start, ex_branch_taken;
  logic       mem_req, mem_ready;
  logic [5:0] stall;
  logic       flush_if_id, flush_id_ex, mc_busy, mc_done, mem_timeout;

  int compared   = 0;
  int mismatched = 0;

  int mRemain = 0;
  int waitRun = 0;

  stall_ctrl #(
    .MC_LAT      (MC_LAT),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_mc_start     (ex_mc_start),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .stall           (stall),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .mc_busy         (mc_busy),
    .mc_done         (mc_done),
    .mem_timeout     (mem_timeout)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, evaluated on each falling edge while the inputs are
  // stable. mRemain is how many EX cycles the current multi-cycle op still
  // owes after this one; waitRun is the length of the current memory wait.
  always @(negedge clk) begin : modelCompare
    logic       memWait, startNow, mcStall, luHit, flush;
    logic       expBusy, expDone, expTo;
    logic [5:0] expStall;
    int         level;
    expStall = 6'd0;
    flush    = 1'b0;
    expBusy  = 1'b0;
    expDone  = 1'b0;
    expTo    = 1'b0;
    if (!rst_n) begin
      mRemain = 0;
      waitRun = 0;
    end else begin
      memWait  = mem_req && !mem_ready;
      startNow = (mRemain == 0) && ex_mc_start && !memWait;
      expBusy  = (mRemain > 0);
      mcStall  = startNow || (mRemain > 1);
      expDone  = (mRemain == 1) && !memWait;
      flush    = ex_branch_taken && !(memWait || mcStall);
      luHit    = ex_mem_read && (ex_rd != 0) &&
                 ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd)) &&
                 !flush;
      level    = memWait ? 5 : (mcStall ? 4 : (luHit ? 3 : 0));
      expStall = 6'((1 << level) - 1);
      if (memWait) begin
        waitRun = waitRun + 1;
        expTo   = (waitRun % MEM_TIMEOUT) == 0;
      end else begin
        waitRun = 0;
      end
      if (startNow) mRemain = MC_LAT - 1;
      else if (mRemain > 0 && !memWait) mRemain = mRemain - 1;
    end
    compared = compared + 1;
    if ({stall, flush_if_id, flush_id_ex, mc_busy, mc_done, mem_timeout} !==
        {expStall, flush, flush, expBusy, expDone, expTo}) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL model t=%0t got stall=%b fl=%b%b busy=%b done=%b to=%b required stall=%b fl=%b busy=%b done=%b to=%b",
               $time, stall, flush_if_id, flush_id_ex, mc_busy, mc_done, mem_timeout,
               expStall, flush, expBusy, expDone, expTo);
    end
  end

  // Drives one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic ld,
                               input logic mcs, input logic br,
                               input logic req, input logic rdy);
    @(posedge clk);
    #1;
    id_rs1          = rs1;
    id_rs1_used     = u1;
    id_rs2          = rs2;
    id_rs2_used     = u2;
    ex_rd           = rd;
    ex_mem_read     = ld;
    ex_mc_start     = mcs;
    ex_branch_taken = br;
    mem_req         = req;
    mem_ready       = rdy;
  endtask

  // Literal expectation for the current cycle, sampled after the falling edge.
  task automatic checkOutput(input string name, input logic [5:0] expStall,
                             input logic expFlush, input logic expBusy,
                             input logic expDone, input logic expTo);
    @(negedge clk);
    #1;
    compared = compared + 1;
    if ({stall, flush_if_id, flush_id_ex, mc_busy, mc_done, mem_timeout} !==
        {expStall, expFlush, expFlush, expBusy, expDone, expTo}) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s got stall=%b fl=%b%b busy=%b done=%b to=%b required stall=%b fl=%b busy=%b done=%b to=%b",
               name, stall, flush_if_id, flush_id_ex, mc_busy, mc_done, mem_timeout,
               expStall, expFlush, expBusy, expDone, expTo);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_mem_read = 1'b0; ex_mc_start = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;

    // Outputs forced quiet in reset even with every stall source active.
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("reset_forced", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("reset_forced2", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle();
    rst_n = 1'b1;
    checkOutput("reset_release", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load-use hazards.
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs1", 6'b000111, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("lu_after", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd3, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs2", 6'b000111, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd9, 1'b0, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_unused_src", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_x0", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Multi-cycle op held in EX for its full occupancy.
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("mc_c1", 6'b001111, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("mc_c2", 6'b001111, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("mc_c3", 6'b001111, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("mc_c4_done", 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0);
    idleCycle();
    checkOutput("mc_idle", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Memory wait inside MC_BUSY freezes the count; timeout on wait cycle 3.
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("mcw_start", 6'b001111, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("mcw_wait", 6'b011111, 1'b0, 1'b1, 1'b0, (i == 3));
    end
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("mcw_resume1", 6'b001111, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("mcw_resume2", 6'b001111, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("mcw_done", 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0);
    idleCycle();
    checkOutput("mcw_idle", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Long memory wait from idle: pulses on wait cycles 3 and 6.
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("timeout", 6'b011111, 1'b0, 1'b0, 1'b0, (i == 3 || i == 6));
    end

    // Branch flush beats load-use; a memory wait blocks the flush.
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("flush_lu", 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_memwait", 6'b011111, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("flush_after_wait", 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of an op aborts it without mc_done.
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_start", 6'b001111, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    checkOutput("abort_reset", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle();
    rst_n = 1'b1;
    checkOutput("abort_after", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("abort_no_done", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic; the model process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      logic req;
      req = ($urandom_range(0, 2) == 0);
      applyStimulus(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                    req, ($urandom_range(0, 1) == 1));
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
    end

    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
